// File: rtl/iq_jump_pkg.sv
// Shared decode field positions, FSM states and operand-readiness helper
// for the jump-unit issue queue.
package iq_jump_pkg;

    localparam int DEC_RS1_HI  = 49;
    localparam int DEC_RS1_LO  = 45;
    localparam int DEC_RS2_HI  = 44;
    localparam int DEC_RS2_LO  = 40;
    localparam int DEC_RE1_BIT = 38;
    localparam int DEC_RE2_BIT = 37;

    typedef enum logic [1:0] {
        IQJ_IDLE    = 2'd0,
        IQJ_ISSUE   = 2'd1,
        IQJ_RESOLVE = 2'd2
    } iqj_state_t;

    // x0 never has a pending write, whatever the scoreboard says.
    function automatic logic src_ready(input logic needed, input logic [4:0] rs,
                                       input logic [31:0] busy);
        return !needed || (rs == 5'd0) || !busy[rs];
    endfunction

endpackage

// File: rtl/iq_jump_fifo.sv
// Circular entry store for the jump issue queue: push at tail, pop at head,
// clear drops every entry by pulling head up to tail.
module iq_jump_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int W     = 104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     head,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);
    import iq_jump_pkg::*;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    assign head  = mem[head_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= tail_ptr;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iq_jump.sv
// In-order issue queue for the jump unit: one control-flow instruction in
// flight, issued when its sources are ready, flushed on a taken redirect.
module iq_jump #(
    parameter int DEPTH  = 4,
    parameter int INST_W = 72,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispatch_en_i,
    input  logic [31:0]       dispatch_addr_i,
    input  logic [INST_W-1:0] dispatch_inst_i,
    output logic              dispatch_ready_o,
    input  logic [31:0]       reg_busy_i,
    output logic              iq_jump_0_en_o,
    output logic [31:0]       iq_jump_0_addr_o,
    output logic [INST_W-1:0] iq_jump_0_inst_o,
    input  logic              jump_flag_i,
    input  logic              jump_continue_i,
    output logic              flush_o,
    output logic [PTR_W:0]    count_o
);
    import iq_jump_pkg::*;

    localparam int W = 32 + INST_W;

    iqj_state_t       state;
    logic [W-1:0]     head;
    logic [31:0]      head_addr;
    logic [INST_W-1:0] head_inst;
    logic             full;
    logic             empty;
    logic             head_ready;
    logic             push;
    logic             pop;
    logic             clear;

    assign head_addr = head[W-1:INST_W];
    assign head_inst = head[INST_W-1:0];

    assign head_ready =
        src_ready(head_inst[DEC_RE1_BIT], head_inst[DEC_RS1_HI:DEC_RS1_LO], reg_busy_i) &&
        src_ready(head_inst[DEC_RE2_BIT], head_inst[DEC_RS2_HI:DEC_RS2_LO], reg_busy_i);

    // A taken redirect discards the queue and any dispatch arriving alongside it.
    assign clear = (state == IQJ_RESOLVE) && jump_flag_i;
    assign push  = dispatch_en_i && !full && !clear;
    assign pop   = (state == IQJ_IDLE) && !empty && head_ready;

    assign dispatch_ready_o = !full;

    iq_jump_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   ({dispatch_addr_i, dispatch_inst_i}),
        .head  (head),
        .count (count_o),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IQJ_IDLE;
            iq_jump_0_en_o   <= 1'b0;
            iq_jump_0_addr_o <= '0;
            iq_jump_0_inst_o <= '0;
            flush_o          <= 1'b0;
        end else begin
            flush_o <= 1'b0;
            case (state)
                IQJ_IDLE: begin
                    if (pop) begin
                        iq_jump_0_en_o   <= 1'b1;
                        iq_jump_0_addr_o <= head_addr;
                        iq_jump_0_inst_o <= head_inst;
                        state            <= IQJ_ISSUE;
                    end
                end
                IQJ_ISSUE: begin
                    iq_jump_0_en_o <= 1'b0;
                    state          <= IQJ_RESOLVE;
                end
                IQJ_RESOLVE: begin
                    if (jump_flag_i) begin
                        flush_o <= 1'b1;
                        state   <= IQJ_IDLE;
                    end else if (jump_continue_i) begin
                        state <= IQJ_IDLE;
                    end else begin
                        // ecall/ebreak resolve with neither flag raised
                        state <= IQJ_IDLE;
                    end
                end
                default: begin
                    iq_jump_0_en_o <= 1'b0;
                    state          <= IQJ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iq_jump.sv
// Directed bench for iq_jump: queue-level reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_iq_jump;

    localparam int DEPTH  = 4;
    localparam int INST_W = 72;
    localparam int PTR_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              dispatch_en_i;
    logic [31:0]       dispatch_addr_i;
    logic [INST_W-1:0] dispatch_inst_i;
    logic              dispatch_ready_o;
    logic [31:0]       reg_busy_i;
    logic              iq_jump_0_en_o;
    logic [31:0]       iq_jump_0_addr_o;
    logic [INST_W-1:0] iq_jump_0_inst_o;
    logic              jump_flag_i;
    logic              jump_continue_i;
    logic              flush_o;
    logic [PTR_W:0]    count_o;

    iq_jump #(.DEPTH(DEPTH), .INST_W(INST_W), .PTR_W(PTR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .dispatch_en_i    (dispatch_en_i),
        .dispatch_addr_i  (dispatch_addr_i),
        .dispatch_inst_i  (dispatch_inst_i),
        .dispatch_ready_o (dispatch_ready_o),
        .reg_busy_i       (reg_busy_i),
        .iq_jump_0_en_o   (iq_jump_0_en_o),
        .iq_jump_0_addr_o (iq_jump_0_addr_o),
        .iq_jump_0_inst_o (iq_jump_0_inst_o),
        .jump_flag_i      (jump_flag_i),
        .jump_continue_i  (jump_continue_i),
        .flush_o          (flush_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    function automatic logic [INST_W-1:0] mk_inst(input logic [31:0] pc,
                                                  input logic [4:0] rs1, input logic re1,
                                                  input logic [4:0] rs2, input logic re2);
        logic [INST_W-1:0] v;
        v         = '0;
        v[31:0]   = pc ^ 32'h5A5A_0063;
        v[71:50]  = pc[21:0];
        v[49:45]  = rs1;
        v[44:40]  = rs2;
        v[38]     = re1;
        v[37]     = re2;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0]       addr;
        logic [INST_W-1:0] inst;
    } ent_t;

    ent_t              q[$];
    int                busy_for = 0;   // cycles until the unit can take a new issue
    logic              armed    = 1'b0;
    logic              e_en, e_flush;
    logic [31:0]       e_addr;
    logic [INST_W-1:0] e_inst;

    function automatic logic model_ready(input logic [INST_W-1:0] ins, input logic [31:0] busy);
        logic [4:0] r1, r2;
        logic ok1, ok2;
        r1  = ins[49:45];
        r2  = ins[44:40];
        ok1 = !ins[38] || r1 == 0 || busy[r1] == 1'b0;
        ok2 = !ins[37] || r2 == 0 || busy[r2] == 1'b0;
        return ok1 && ok2;
    endfunction

    always @(posedge clk) begin
        cycle++;
        if (rst) begin
            armed    = 1'b1;
            q.delete();
            busy_for = 0;
            e_en     = 1'b0;
            e_addr   = '0;
            e_inst   = '0;
            e_flush  = 1'b0;
        end else begin
            int   n;
            logic flushing;
            ent_t ne;
            n        = q.size();
            flushing = (busy_for == 1) && jump_flag_i;
            e_flush  = flushing;
            e_en     = 1'b0;
            if (busy_for == 0 && n > 0 && model_ready(q[0].inst, reg_busy_i)) begin
                e_en     = 1'b1;
                e_addr   = q[0].addr;
                e_inst   = q[0].inst;
                void'(q.pop_front());
                busy_for = 2;
            end else if (busy_for > 0) begin
                busy_for--;
            end
            if (flushing) begin
                q.delete();
            end else if (dispatch_en_i && n < DEPTH) begin
                ne.addr = dispatch_addr_i;
                ne.inst = dispatch_inst_i;
                q.push_back(ne);
            end
        end
    end

    logic [31:0] iss_addr[$];
    int          iss_cyc[$];

    always @(negedge clk) begin
        if (armed) begin
            chk("model_en", iq_jump_0_en_o, e_en);
            chk("model_addr", iq_jump_0_addr_o, e_addr);
            chk("model_inst", iq_jump_0_inst_o, e_inst);
            chk("model_flush", flush_o, e_flush);
            chk("model_count", count_o, q.size());
            chk("model_ready", dispatch_ready_o, q.size() < DEPTH);
            if (iq_jump_0_en_o === 1'b1) begin
                iss_addr.push_back(iq_jump_0_addr_o);
                iss_cyc.push_back(cycle);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_entry(input logic [31:0] pc, input logic [INST_W-1:0] ins, input int max_wait);
        logic acc;
        acc             = 1'b0;
        dispatch_en_i   = 1'b1;
        dispatch_addr_i = pc;
        dispatch_inst_i = ins;
        for (int k = 0; k < max_wait && !acc; k++) begin
            acc = dispatch_ready_o;
            cyc(1);
        end
        dispatch_en_i = 1'b0;
        chk("push_accepted", acc, 1'b1);
    endtask

    task automatic wait_issues(input int n, input int budget);
        for (int k = 0; k < budget && iss_addr.size() < n; k++) cyc(1);
        chk("issue_budget", iss_addr.size() >= n, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst             = 1'b1;
        dispatch_en_i   = 1'b0;
        dispatch_addr_i = '0;
        dispatch_inst_i = '0;
        reg_busy_i      = '0;
        jump_flag_i     = 1'b0;
        jump_continue_i = 1'b0;

        // Reset and basic issue; busy x0/x5 must not stall an entry that reads nothing
        cyc(2);
        chk("rst_ready", dispatch_ready_o, 1'b1);
        chk("rst_en", iq_jump_0_en_o, 1'b0);
        chk("rst_count", count_o, 0);
        chk("rst_flush", flush_o, 1'b0);
        rst             = 1'b0;
        reg_busy_i      = 32'h0000_0021;
        dispatch_en_i   = 1'b1;
        dispatch_addr_i = 32'h100;
        dispatch_inst_i = mk_inst(32'h100, 5'd5, 1'b0, 5'd0, 1'b0);
        cyc(1);
        dispatch_en_i = 1'b0;
        chk("jal_count1", count_o, 1);
        cyc(1);
        chk("jal_en", iq_jump_0_en_o, 1'b1);
        chk("jal_addr", iq_jump_0_addr_o, 32'h100);
        chk("jal_count0", count_o, 0);
        cyc(1);
        chk("jal_en_drop", iq_jump_0_en_o, 1'b0);
        cyc(3);

        // Operand stall: rs1=x5 busy, rs2=x0 needed but always ready
        base = iss_addr.size();
        push_entry(32'h140, mk_inst(32'h140, 5'd5, 1'b1, 5'd0, 1'b1), 4);
        cyc(4);
        chk("stall_no_issue", iss_addr.size(), base);
        chk("stall_count", count_o, 1);
        reg_busy_i = '0;
        cyc(1);
        chk("stall_release_en", iq_jump_0_en_o, 1'b1);
        chk("stall_release_addr", iq_jump_0_addr_o, 32'h140);
        cyc(4);

        // Taken flush
        base            = iss_addr.size();
        dispatch_en_i   = 1'b1;
        dispatch_addr_i = 32'h200;
        dispatch_inst_i = mk_inst(32'h200, 5'd2, 1'b1, 5'd3, 1'b1);
        cyc(1);
        dispatch_addr_i = 32'h204;
        dispatch_inst_i = mk_inst(32'h204, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(1);
        chk("tk_issue_en", iq_jump_0_en_o, 1'b1);
        chk("tk_issue_addr", iq_jump_0_addr_o, 32'h200);
        dispatch_addr_i = 32'h208;
        dispatch_inst_i = mk_inst(32'h208, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(1);
        chk("tk_count2", count_o, 2);
        jump_flag_i     = 1'b1;
        dispatch_addr_i = 32'h20C;
        dispatch_inst_i = mk_inst(32'h20C, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(1);
        jump_flag_i   = 1'b0;
        dispatch_en_i = 1'b0;
        chk("tk_flush", flush_o, 1'b1);
        chk("tk_count0", count_o, 0);
        cyc(1);
        chk("tk_flush_once", flush_o, 1'b0);
        cyc(8);
        chk("tk_no_more_issue", iss_addr.size(), base + 1);

        // Not taken: same sequence, continue reported
        base            = iss_addr.size();
        dispatch_en_i   = 1'b1;
        dispatch_addr_i = 32'h200;
        dispatch_inst_i = mk_inst(32'h200, 5'd2, 1'b1, 5'd3, 1'b1);
        cyc(1);
        dispatch_addr_i = 32'h204;
        dispatch_inst_i = mk_inst(32'h204, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(1);
        dispatch_addr_i = 32'h208;
        dispatch_inst_i = mk_inst(32'h208, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(1);
        jump_continue_i = 1'b1;
        dispatch_addr_i = 32'h20C;
        dispatch_inst_i = mk_inst(32'h20C, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(1);
        jump_continue_i = 1'b0;
        dispatch_en_i   = 1'b0;
        chk("nt_no_flush", flush_o, 1'b0);
        chk("nt_count3", count_o, 3);
        wait_issues(base + 4, 30);
        if (iss_addr.size() >= base + 4) begin
            chk("nt_order1", iss_addr[base+1], 32'h204);
            chk("nt_order2", iss_addr[base+2], 32'h208);
            chk("nt_order3", iss_addr[base+3], 32'h20C);
            chk("nt_gap", iss_cyc[base+2] - iss_cyc[base+1], 3);
        end
        cyc(4);

        // Full and wrap: head waits on x1
        base       = iss_addr.size();
        reg_busy_i = 32'h0000_0002;
        push_entry(32'h300, mk_inst(32'h300, 5'd1, 1'b1, 5'd0, 1'b0), 4);
        push_entry(32'h304, mk_inst(32'h304, 5'd0, 1'b0, 5'd1, 1'b0), 4);
        push_entry(32'h308, mk_inst(32'h308, 5'd0, 1'b0, 5'd0, 1'b0), 4);
        push_entry(32'h30C, mk_inst(32'h30C, 5'd0, 1'b0, 5'd0, 1'b0), 4);
        chk("full_ready0", dispatch_ready_o, 1'b0);
        chk("full_count4", count_o, 4);
        dispatch_en_i   = 1'b1;
        dispatch_addr_i = 32'h310;
        dispatch_inst_i = mk_inst(32'h310, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(3);
        chk("full_held_count", count_o, 4);
        chk("full_no_issue", iss_addr.size(), base);
        reg_busy_i = '0;
        push_entry(32'h310, mk_inst(32'h310, 5'd0, 1'b0, 5'd0, 1'b0), 20);
        for (int i = 5; i < 8; i++)
            push_entry(32'h300 + 32'(4*i), mk_inst(32'h300 + 32'(4*i), 5'd0, 1'b0, 5'd0, 1'b0), 20);
        wait_issues(base + 8, 60);
        if (iss_addr.size() >= base + 8) begin
            for (int i = 0; i < 8; i++)
                chk($sformatf("wrap_pc%0d", i), iss_addr[base+i], 32'h300 + 32'(4*i));
        end
        cyc(4);

        // Reset in RESOLVE with a taken flag
        push_entry(32'h400, mk_inst(32'h400, 5'd0, 1'b0, 5'd0, 1'b0), 4);
        push_entry(32'h404, mk_inst(32'h404, 5'd0, 1'b0, 5'd0, 1'b0), 4);
        for (int k = 0; k < 10 && iq_jump_0_en_o !== 1'b1; k++) cyc(1);
        chk("mid_issue_seen", iq_jump_0_en_o, 1'b1);
        cyc(1);
        rst             = 1'b1;
        jump_flag_i     = 1'b1;
        dispatch_en_i   = 1'b1;
        dispatch_addr_i = 32'h408;
        dispatch_inst_i = mk_inst(32'h408, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc(1);
        rst           = 1'b0;
        jump_flag_i   = 1'b0;
        dispatch_en_i = 1'b0;
        chk("mid_en", iq_jump_0_en_o, 1'b0);
        chk("mid_addr", iq_jump_0_addr_o, 32'h0);
        chk("mid_inst", iq_jump_0_inst_o, '0);
        chk("mid_flush", flush_o, 1'b0);
        chk("mid_count", count_o, 0);
        chk("mid_ready", dispatch_ready_o, 1'b1);
        cyc(1);
        chk("mid_flush_after", flush_o, 1'b0);
        chk("mid_count_after", count_o, 0);
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
